// File: rtl/buffer_tile_packer.sv
// buffer_tile_packer: packs a DATA_WIDTH element stream into TILE_WIDTH tile writes for the buffer file.
// Build option PACKER_ZERO_FILL_EN: pad every vector with zero tiles up to TILE_COUNT writes.
module buffer_tile_packer #(
   parameter int BUFFER_WIDTH = 1024,
   parameter int BUFFER_COUNT = 2,
   parameter int TILE_WIDTH   = 256,
   parameter int DATA_WIDTH   = 8,
   parameter int TILE_SIZE    = TILE_WIDTH / DATA_WIDTH,
   localparam int CAPACITY    = BUFFER_WIDTH / DATA_WIDTH,
   localparam int TILE_COUNT  = BUFFER_WIDTH / TILE_WIDTH,
   localparam int LEN_W       = $clog2(CAPACITY + 1),
   localparam int BUF_W       = $clog2(BUFFER_COUNT)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [BUF_W-1:0]      dest_buffer,
   input  logic [LEN_W-1:0]      length,
   input  logic                  elem_valid,
   input  logic [DATA_WIDTH-1:0] elem_data,
   output logic                  elem_ready,
   output logic                  buf_write_enable,
   output logic [TILE_WIDTH-1:0] buf_write_data,
   output logic [BUF_W-1:0]      buf_write_buffer,
   output logic                  buf_reset_indices_enable,
   output logic [BUF_W-1:0]      buf_reset_indices_buffer,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);
   localparam int LANE_W = $clog2(TILE_SIZE);
   localparam int TCNT_W = $clog2(TILE_COUNT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PACK,
      S_WRITE,
`ifdef PACKER_ZERO_FILL_EN
      S_FILL,
`endif
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [BUF_W-1:0]      dest_q, dest_d;
   logic [LEN_W-1:0]      len_q, len_d;
   logic [TILE_WIDTH-1:0] pack_q, pack_d;
   logic [LANE_W-1:0]     lane_q, lane_d;
   logic [LEN_W-1:0]      elem_cnt_q, elem_cnt_d;
   logic [TCNT_W-1:0]     tile_cnt_q, tile_cnt_d;
   logic                  first_q, first_d;
   logic                  wr_en_q, wr_en_d;
   logic                  rst_idx_q, rst_idx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;

   logic                  start_ok;
   logic                  tile_full;
   logic                  last_elem;
   logic                  all_consumed;
   logic [TCNT_W-1:0]     tile_inc;

   assign start_ok     = (length != '0) && (length <= LEN_W'(CAPACITY));
   assign tile_full    = (lane_q == LANE_W'(TILE_SIZE - 1));
   assign last_elem    = (elem_cnt_q == len_q - LEN_W'(1));
   assign all_consumed = (elem_cnt_q == len_q);
   assign tile_inc     = tile_cnt_q + 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         dest_q     <= '0;
         len_q      <= '0;
         pack_q     <= '0;
         lane_q     <= '0;
         elem_cnt_q <= '0;
         tile_cnt_q <= '0;
         first_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         rst_idx_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         dest_q     <= dest_d;
         len_q      <= len_d;
         pack_q     <= pack_d;
         lane_q     <= lane_d;
         elem_cnt_q <= elem_cnt_d;
         tile_cnt_q <= tile_cnt_d;
         first_q    <= first_d;
         wr_en_q    <= wr_en_d;
         rst_idx_q  <= rst_idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start && start_ok) state_d = S_PACK;
         S_PACK:  if (elem_valid && (tile_full || last_elem)) state_d = S_WRITE;
         S_WRITE: begin
            if (!all_consumed) begin
               state_d = S_PACK;
            end else begin
`ifdef PACKER_ZERO_FILL_EN
               state_d = (tile_inc == TCNT_W'(TILE_COUNT)) ? S_DONE : S_FILL;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef PACKER_ZERO_FILL_EN
         S_FILL:  if (tile_inc == TCNT_W'(TILE_COUNT)) state_d = S_DONE;
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath: pack register doubles as the write-data register, so it is cleared after each tile.
   always_comb begin
      dest_d     = dest_q;
      len_d      = len_q;
      pack_d     = pack_q;
      lane_d     = lane_q;
      elem_cnt_d = elem_cnt_q;
      tile_cnt_d = tile_cnt_q;
      first_d    = first_q;
      case (state_q)
         S_IDLE: begin
            if (start && start_ok) begin
               dest_d     = dest_buffer;
               len_d      = length;
               pack_d     = '0;
               lane_d     = '0;
               elem_cnt_d = '0;
               tile_cnt_d = '0;
               first_d    = 1'b1;
            end
         end
         S_PACK: begin
            if (elem_valid) begin
               pack_d[lane_q*DATA_WIDTH +: DATA_WIDTH] = elem_data;
               lane_d     = lane_q + 1'b1;
               elem_cnt_d = elem_cnt_q + 1'b1;
            end
         end
         S_WRITE: begin
            first_d    = 1'b0;
            pack_d     = '0;
            lane_d     = '0;
            tile_cnt_d = tile_inc;
         end
`ifdef PACKER_ZERO_FILL_EN
         S_FILL:  tile_cnt_d = tile_inc;
`endif
         default: ;
      endcase
   end

   always_comb begin
`ifdef PACKER_ZERO_FILL_EN
      wr_en_d = (state_d == S_WRITE) || (state_d == S_FILL);
`else
      wr_en_d = (state_d == S_WRITE);
`endif
      rst_idx_d = (state_d == S_WRITE) && first_q;
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
      error_d   = (state_q == S_IDLE) && start && !start_ok;
   end

   assign elem_ready               = (state_q == S_PACK);
   assign buf_write_enable         = wr_en_q;
   assign buf_write_data           = pack_q;
   assign buf_write_buffer         = dest_q;
   assign buf_reset_indices_enable = rst_idx_q;
   assign buf_reset_indices_buffer = dest_q;
   assign busy                     = busy_q;
   assign done                     = done_q;
   assign error                    = error_q;

endmodule

// File: tb/tb_buffer_tile_packer.sv
// Testbench for buffer_tile_packer: random streams checked against a tile-level reference model.
// Honours PACKER_ZERO_FILL_EN when computing the expected tile list.
module tb_buffer_tile_packer;
   localparam int DW  = 8;
   localparam int TS  = 32;
   localparam int TW  = 256;
   localparam int TC  = 4;
   localparam int CAP = 128;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic [0:0]    dest_buffer;
   logic [7:0]    length;
   logic          elem_valid;
   logic [DW-1:0] elem_data;
   logic          elem_ready;
   logic          buf_write_enable;
   logic [TW-1:0] buf_write_data;
   logic [0:0]    buf_write_buffer;
   logic          buf_reset_indices_enable;
   logic [0:0]    buf_reset_indices_buffer;
   logic          busy;
   logic          done;
   logic          error;

   always #5 clk = ~clk;

   buffer_tile_packer dut (
      .clk(clk), .reset_n(reset_n), .start(start), .dest_buffer(dest_buffer), .length(length),
      .elem_valid(elem_valid), .elem_data(elem_data), .elem_ready(elem_ready),
      .buf_write_enable(buf_write_enable), .buf_write_data(buf_write_data),
      .buf_write_buffer(buf_write_buffer), .buf_reset_indices_enable(buf_reset_indices_enable),
      .buf_reset_indices_buffer(buf_reset_indices_buffer), .busy(busy), .done(done), .error(error)
   );

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: log every write-strobe cycle and count pulses, sampled mid-cycle.
   logic [TW-1:0] got_data[$];
   int got_buf[$];
   int got_rst[$];
   int got_cyc[$];
   int done_cnt = 0, done_cyc = 0, err_cnt = 0, busy_seen = 0;
   int rdy_in_write = 0, idx_buf_bad = 0, busy_after_done = 0;
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      if (buf_write_enable) begin
         got_data.push_back(buf_write_data);
         got_buf.push_back(int'(buf_write_buffer));
         got_rst.push_back(int'(buf_reset_indices_enable));
         got_cyc.push_back(cyc);
         if (elem_ready) rdy_in_write <= rdy_in_write + 1;
         if (buf_reset_indices_buffer !== buf_write_buffer) idx_buf_bad <= idx_buf_bad + 1;
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (error) err_cnt <= err_cnt + 1;
      if (busy) busy_seen <= busy_seen + 1;
      if (prev_done && busy) busy_after_done <= busy_after_done + 1;
      prev_done <= done;
   end

   logic [DW-1:0] elems[CAP];
   logic [TW-1:0] exp_data[$];
   int acc_cyc[CAP];
   int accepted;

   // Reference model: tile t holds elements t*TS.. in lanes 0.., unused lanes zero.
   task automatic build_exp(input int len);
      logic [TW-1:0] w;
      exp_data.delete();
      for (int t = 0; t * TS < len; t++) begin
         w = '0;
         for (int i = 0; i < TS; i++)
            if (t * TS + i < len) w[i*DW +: DW] = elems[t*TS + i];
         exp_data.push_back(w);
      end
`ifdef PACKER_ZERO_FILL_EN
      while (exp_data.size() < TC) exp_data.push_back('0);
`endif
   endtask

   task automatic do_start(input int len, input int dst);
      start = 1'b1;
      length = len[7:0];
      dest_buffer = dst[0:0];
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // mode 0: back-to-back, 1: valid 1,0,0 repeating, 2: random valid
   task automatic stream(input int n, input int mode, input int stop_after);
      int slot = 0;
      logic v;
      accepted = 0;
      while (accepted < n && accepted < stop_after && slot < 4000) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = (slot % 3 == 0);
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         elem_valid = v;
         elem_data = elems[accepted];
         @(negedge clk);
         if (elem_valid && elem_ready) begin
            acc_cyc[accepted] = cyc;
            accepted++;
         end
         @(posedge clk); #1;
         slot++;
      end
      elem_valid = 1'b0;
   endtask

   task automatic wait_done(input int base);
      int b = 0;
      while (done_cnt == base && b < 400) begin
         @(negedge clk);
         b++;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; dest_buffer = '0; length = '0;
      elem_valid = 1'b0; elem_data = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (buf_write_enable !== 1'b0 || buf_reset_indices_enable !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_strobes: got we=%b ri=%b required 0 0", buf_write_enable, buf_reset_indices_enable);
      end
      vectors++;
      if (buf_write_data !== '0 || buf_write_buffer !== '0 || buf_reset_indices_buffer !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got data=%h buf=%b required 0", buf_write_data, buf_write_buffer);
      end
      vectors++;
      if ({elem_ready, busy, done, error} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_status: got rdy/busy/done/err=%b required 0000", {elem_ready, busy, done, error});
      end
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single_tile();
      int wb = got_data.size();
      int db = done_cnt;
      int n;
      for (int i = 0; i < 32; i++) elems[i] = 8'(i);
      build_exp(32);
      do_start(32, 1);
      stream(32, 0, 32);
      wait_done(db);
      n = got_data.size() - wb;
      $display("txn single_tile len=32 dest=1 writes=%0d", n);
      vectors++;
      if (accepted !== 32) begin
         miscompares++;
         $display("FAIL single_accepted: got %0d required 32", accepted);
      end
      vectors++;
      if (n !== exp_data.size()) begin
         miscompares++;
         $display("FAIL single_write_count: got %0d required %0d", n, exp_data.size());
      end else begin
         for (int j = 0; j < n; j++) begin
            vectors++;
            if (got_data[wb+j] !== exp_data[j] || got_buf[wb+j] !== 1 || got_rst[wb+j] !== (j == 0 ? 1 : 0)) begin
               miscompares++;
               $display("FAIL single_tile%0d: got data=%h buf=%0d ri=%0d required data=%h buf=1 ri=%0d",
                        j, got_data[wb+j], got_buf[wb+j], got_rst[wb+j], exp_data[j], (j == 0 ? 1 : 0));
            end
         end
         vectors++;
         if (got_cyc[wb] !== acc_cyc[31] + 1) begin
            miscompares++;
            $display("FAIL single_write_latency: got cycle %0d required %0d", got_cyc[wb], acc_cyc[31] + 1);
         end
         vectors++;
         if (done_cyc !== got_cyc[wb+n-1] + 1) begin
            miscompares++;
            $display("FAIL single_done_latency: got cycle %0d required %0d", done_cyc, got_cyc[wb+n-1] + 1);
         end
      end
      vectors++;
      if (done_cnt - db !== 1) begin
         miscompares++;
         $display("FAIL single_done_count: got %0d required 1", done_cnt - db);
      end
   endtask

   task automatic test_two_tiles();
      int wb = got_data.size();
      int db = done_cnt;
      int n;
      for (int i = 0; i < 40; i++) elems[i] = 8'(8'h80 + i);
      build_exp(40);
      do_start(40, 0);
      stream(40, 0, 40);
      wait_done(db);
      n = got_data.size() - wb;
      $display("txn two_tiles len=40 dest=0 writes=%0d", n);
      vectors++;
      if (n !== exp_data.size()) begin
         miscompares++;
         $display("FAIL two_write_count: got %0d required %0d", n, exp_data.size());
      end else begin
         for (int j = 0; j < n; j++) begin
            vectors++;
            if (got_data[wb+j] !== exp_data[j] || got_buf[wb+j] !== 0 || got_rst[wb+j] !== (j == 0 ? 1 : 0)) begin
               miscompares++;
               $display("FAIL two_tile%0d: got data=%h buf=%0d ri=%0d required data=%h buf=0 ri=%0d",
                        j, got_data[wb+j], got_buf[wb+j], got_rst[wb+j], exp_data[j], (j == 0 ? 1 : 0));
            end
         end
         vectors++;
         if (done_cyc !== got_cyc[wb+n-1] + 1) begin
            miscompares++;
            $display("FAIL two_done_latency: got cycle %0d required %0d", done_cyc, got_cyc[wb+n-1] + 1);
         end
      end
   endtask

   task automatic test_throttled();
      int wb = got_data.size();
      int db = done_cnt;
      int rb = rdy_in_write;
      int n;
      for (int i = 0; i < CAP; i++) elems[i] = 8'($urandom);
      build_exp(128);
      do_start(128, 1);
      stream(128, 1, 128);
      wait_done(db);
      n = got_data.size() - wb;
      $display("txn throttled len=128 dest=1 writes=%0d", n);
      vectors++;
      if (accepted !== 128) begin
         miscompares++;
         $display("FAIL throttled_accepted: got %0d required 128", accepted);
      end
      vectors++;
      if (n !== exp_data.size()) begin
         miscompares++;
         $display("FAIL throttled_write_count: got %0d required %0d", n, exp_data.size());
      end else begin
         for (int j = 0; j < n; j++) begin
            vectors++;
            if (got_data[wb+j] !== exp_data[j] || got_rst[wb+j] !== (j == 0 ? 1 : 0)) begin
               miscompares++;
               $display("FAIL throttled_tile%0d: got data=%h ri=%0d required data=%h", j, got_data[wb+j], got_rst[wb+j], exp_data[j]);
            end
         end
      end
      vectors++;
      if (rdy_in_write - rb !== 0) begin
         miscompares++;
         $display("FAIL throttled_ready_in_write: got %0d cycles required 0", rdy_in_write - rb);
      end
   endtask

   task automatic test_errors();
      int wb = got_data.size();
      int db = done_cnt;
      int eb = err_cnt;
      int bb = busy_seen;
      do_start(0, 0);
      repeat (2) @(posedge clk);
      #1;
      do_start(129, 1);
      repeat (3) @(posedge clk);
      #1;
      $display("txn bad_starts len=0,129 errors=%0d", err_cnt - eb);
      vectors++;
      if (err_cnt - eb !== 2) begin
         miscompares++;
         $display("FAIL error_pulses: got %0d required 2", err_cnt - eb);
      end
      vectors++;
      if (got_data.size() - wb !== 0 || busy_seen - bb !== 0) begin
         miscompares++;
         $display("FAIL error_side_effects: got writes=%0d busy_cycles=%0d required 0 0", got_data.size() - wb, busy_seen - bb);
      end
      // second start while a vector is in flight must be ignored
      wb = got_data.size();
      eb = err_cnt;
      for (int i = 0; i < 32; i++) elems[i] = 8'($urandom);
      build_exp(32);
      do_start(32, 0);
      do_start(5, 1);
      stream(32, 2, 32);
      wait_done(db);
      $display("txn start_while_busy len=32 dest=0 writes=%0d", got_data.size() - wb);
      vectors++;
      if (done_cnt - db !== 1 || err_cnt - eb !== 0) begin
         miscompares++;
         $display("FAIL busy_start: got done=%0d err=%0d required 1 0", done_cnt - db, err_cnt - eb);
      end
      vectors++;
      if (got_data.size() - wb !== exp_data.size()) begin
         miscompares++;
         $display("FAIL busy_start_writes: got %0d required %0d", got_data.size() - wb, exp_data.size());
      end else if (got_data[wb] !== exp_data[0] || got_buf[wb] !== 0) begin
         miscompares++;
         $display("FAIL busy_start_data: got %h buf=%0d required %h buf=0", got_data[wb], got_buf[wb], exp_data[0]);
      end
   endtask

   task automatic test_reset_abort();
      int wb = got_data.size();
      int db = done_cnt;
      for (int i = 0; i < 32; i++) elems[i] = 8'(i);
      do_start(32, 0);
      stream(32, 0, 20);
      reset_n = 1'b0;
      #1;
      $display("txn reset_abort after=%0d elements", accepted);
      vectors++;
      if ({busy, elem_ready, buf_write_enable, done} !== 4'b0000 || buf_write_data !== '0) begin
         miscompares++;
         $display("FAIL abort_outputs: got busy/rdy/we/done=%b data=%h required 0000 0",
                  {busy, elem_ready, buf_write_enable, done}, buf_write_data);
      end
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (got_data.size() - wb !== 0 || done_cnt - db !== 0) begin
         miscompares++;
         $display("FAIL abort_no_write: got writes=%0d dones=%0d required 0 0", got_data.size() - wb, done_cnt - db);
      end
      test_single_tile();
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         int len = $urandom_range(1, CAP);
         int dst = $urandom_range(0, 1);
         int wb = got_data.size();
         int db = done_cnt;
         int n;
         for (int i = 0; i < CAP; i++) elems[i] = 8'($urandom);
         build_exp(len);
         do_start(len, dst);
         stream(len, 2, len);
         wait_done(db);
         n = got_data.size() - wb;
         $display("txn random%0d len=%0d dest=%0d writes=%0d", r, len, dst, n);
         vectors++;
         if (accepted !== len || done_cnt - db !== 1) begin
            miscompares++;
            $display("FAIL random%0d_flow: got accepted=%0d dones=%0d required %0d 1", r, accepted, done_cnt - db, len);
         end
         vectors++;
         if (n !== exp_data.size()) begin
            miscompares++;
            $display("FAIL random%0d_write_count: got %0d required %0d", r, n, exp_data.size());
         end else begin
            for (int j = 0; j < n; j++) begin
               vectors++;
               if (got_data[wb+j] !== exp_data[j] || got_buf[wb+j] !== dst || got_rst[wb+j] !== (j == 0 ? 1 : 0)) begin
                  miscompares++;
                  $display("FAIL random%0d_tile%0d: got data=%h buf=%0d ri=%0d required data=%h buf=%0d",
                           r, j, got_data[wb+j], got_buf[wb+j], got_rst[wb+j], exp_data[j], dst);
               end
            end
            vectors++;
            if (done_cyc !== got_cyc[wb+n-1] + 1) begin
               miscompares++;
               $display("FAIL random%0d_done_latency: got %0d required %0d", r, done_cyc, got_cyc[wb+n-1] + 1);
            end
         end
      end
      vectors++;
      if (busy_after_done !== 0 || idx_buf_bad !== 0) begin
         miscompares++;
         $display("FAIL busy_and_index_buffer: got busy_after_done=%0d idx_buf_bad=%0d required 0 0", busy_after_done, idx_buf_bad);
      end
   endtask

   initial begin
      test_reset();
      test_single_tile();
      test_two_tiles();
      test_throttled();
      test_errors();
      test_reset_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/buffer_tile_packer.md
Name: buffer_tile_packer

Overview:
Write-side producer for the tile buffer file. It accepts a stream of DATA_WIDTH elements, such as quantized layer outputs, through a valid/ready handshake. It packs TILE_SIZE elements into one TILE_WIDTH word and issues single-cycle tile writes (write_enable/write_data/write_buffer, plus the index-reset strobe on the first tile) to a selected buffer. It sits between the post-processing/quantize stage and the buffer file, and is launched by the controller once per vector.

Parameters:
BUFFER_WIDTH, 1024, bits per buffer; sets capacity.
BUFFER_COUNT, 2, number of destination buffers.
TILE_WIDTH, 256, bits per tile write.
DATA_WIDTH, 8, bits per element.
TILE_SIZE, 32, elements per tile (TILE_WIDTH/DATA_WIDTH).
Derived: CAPACITY = BUFFER_WIDTH/DATA_WIDTH (128 elements); TILE_COUNT = BUFFER_WIDTH/TILE_WIDTH (4 tiles); LEN_W = $clog2(CAPACITY+1).

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  launch pulse, sampled in IDLE only.
dest_buffer  in  $clog2(BUFFER_COUNT)  destination buffer, latched on start.
length  in  LEN_W  element count, latched on start.
elem_valid  in  1  element present.
elem_data  in  DATA_WIDTH  element value.
elem_ready  out  1  packer accepts an element this cycle.
buf_write_enable  out  1  tile write strobe to the buffer file.
buf_write_data  out  TILE_WIDTH  packed tile.
buf_write_buffer  out  $clog2(BUFFER_COUNT)  target buffer.
buf_reset_indices_enable  out  1  restart the tile index; asserted together with the first tile write only.
buf_reset_indices_buffer  out  $clog2(BUFFER_COUNT)  equals buf_write_buffer.
busy  out  1  high from start acceptance until the done cycle inclusive.
done  out  1  one-cycle completion pulse.
error  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the pack register, counters and latched fields are cleared. Reset asserted mid-operation aborts the operation immediately. No partial tile is written, and no done pulse is produced.
- All outputs are registered except elem_ready, which is a decode of state == PACK.
- Handshake: an element is accepted on a cycle where elem_valid && elem_ready. elem_data may change only after acceptance.
- IDLE:
  - start with length == 0 or length > CAPACITY: pulse error the next cycle and stay in IDLE.
  - Otherwise: latch dest_buffer and length, clear the pack word, set lane=0, elem_cnt=0, tile_cnt=0, first=1, and go to PACK.
- PACK:
  - elem_ready=1.
  - On accept, write elem_data to pack[lane*DATA_WIDTH +: DATA_WIDTH]. Lane 0 is the LSBs, matching buffer-file read lane i.
  - Increment lane and elem_cnt.
  - If lane == TILE_SIZE-1 or elem_cnt == length-1 at acceptance, go to WRITE.
- WRITE (exactly one cycle):
  - elem_ready=0.
  - buf_write_enable=1 with buf_write_data = pack. Lanes never written are 0.
  - buf_reset_indices_enable=first.
  - Then clear first and the pack word, set lane=0, and increment tile_cnt.
  - If all length elements have been consumed, go to DONE; otherwise go to PACK.
- DONE: done=1 for one cycle, then IDLE. busy drops on the following cycle.
- Latency:
  - The first write strobe occurs 1 cycle after the acceptance of a tile's last element.
  - done occurs 1 cycle after the final write.
- Throughput: a fully fed stream takes TILE_SIZE+1 cycles per tile, since ready is low during WRITE.
- Tiles written = ceil(length/TILE_SIZE). The buffer file's writing_done is not observed by this block.
- start in any state other than IDLE is ignored, and no error is raised.
- elem_valid in IDLE, WRITE or DONE is ignored.
- Width rules:
  - Comparisons are done at LEN_W bits.
  - lane is $clog2(TILE_SIZE) bits and never exceeds TILE_SIZE-1.
  - tile_cnt is wide enough to hold TILE_COUNT.

Optional Feature:
Macro PACKER_ZERO_FILL_EN.
- Defined: after the last data tile, the FSM enters FILL instead of DONE.
  - FILL writes all-zero tiles with buf_write_enable held for one cycle each, on consecutive cycles, until tile_cnt == TILE_COUNT. It then goes to DONE.
  - The buffer therefore always receives exactly TILE_COUNT writes, and the buffer file's writing_done fires. Stale data past length is cleared.
  - If the data tiles already equal TILE_COUNT, FILL is skipped.
- Undefined: the FILL state is absent and only ceil(length/TILE_SIZE) tiles are written.

Test Plan:
- length=32, dest=1, elements 0x00..0x1F streamed back-to-back -> one write, data byte i = i, reset_indices=1, buffer=1; done 1 cycle after the write; buffer_file read of buffer 1 returns 0x00..0x1F.
- length=40, elements 0x80+i -> two writes. The first has reset_indices=1 and bytes 0x80..0x9F. The second has reset_indices=0, lanes 0-7 = 0xA0..0xA7 and lanes 8-31 = 0.
- length=128 with elem_valid toggling 1,0,0,1... -> four writes, each exactly one cycle, with elem_ready=0 during each WRITE; no element is dropped or duplicated.
- start with length=0, then with length=129 -> error pulse each time, no write, busy stays 0. A start asserted while busy is ignored: exactly one done.
- reset_n asserted after 20 of 32 elements -> outputs 0 immediately, no write issued. A following start with length=32 behaves as in the first scenario.
- PACKER_ZERO_FILL_EN defined, length=40 -> 4 writes: 2 data tiles, then 2 zero tiles; the buffer file's writing_done pulses with the 4th write.
